// File: rtl/orao_vram_arbiter.sv
// Orao video RAM arbiter.
// Shares one single-port, one-cycle-latency RAM between the display fetch
// path and the CPU. Display normally has priority. A CPU request that has
// been denied STARVE_LIMIT consecutive cycles overrides the display, and
// the display request dropped in that cycle is reported and counted.
module orao_vram_arbiter #(
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk_pixel,
   input  logic              reset,
   // display fetch port
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [7:0]        disp_data,
   output logic              disp_valid,
   output logic              disp_miss,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   // RAM port
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   // statistics
   output logic [15:0]       miss_count
);

   typedef enum logic [1:0] {
      CPU_IDLE,
      CPU_WACK,
      CPU_RWAIT,
      CPU_RACK
   } cpu_state_t;

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   cpu_state_t        cpu_state;
   logic [7:0]        starve_cnt;
   logic              disp_rd_pend;
   logic [ADDR_W-1:0] last_addr;
   logic [7:0]        last_wdata;

   logic              cpu_pending;
   logic              cpu_starved;
   logic              grant_cpu;
   logic              grant_disp;
   logic              disp_dropped;

   // Grant decision for the current cycle; a reset cycle grants nothing.
   always_comb begin
      cpu_pending  = cpu_req && (cpu_state == CPU_IDLE) && !reset;
      cpu_starved  = cpu_pending && (starve_cnt == STARVE_MAX);
      grant_cpu    = cpu_starved || (cpu_pending && !disp_req);
      grant_disp   = disp_req && !grant_cpu && !reset;
      disp_dropped = disp_req && !grant_disp;
   end

   // RAM port driven straight from the grant; idle cycles hold the last address.
   always_comb begin
      ram_addr  = last_addr;
      ram_we    = 1'b0;
      ram_wdata = last_wdata;
      if (reset) begin
         ram_addr  = '0;
         ram_wdata = '0;
      end else if (grant_cpu) begin
         ram_addr = cpu_addr;
         ram_we   = cpu_we;
         if (cpu_we) begin
            ram_wdata = cpu_wdata;
         end
      end else if (grant_disp) begin
         ram_addr = disp_addr;
      end
   end

   // Remember the last address and write data presented to the RAM.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         last_addr  <= '0;
         last_wdata <= '0;
      end else begin
         if (grant_cpu || grant_disp) begin
            last_addr <= ram_addr;
         end
         if (grant_cpu && cpu_we) begin
            last_wdata <= cpu_wdata;
         end
      end
   end

   // CPU access sequencer with registered acknowledge and read data.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         cpu_state <= CPU_IDLE;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         case (cpu_state)
            CPU_IDLE: begin
               if (grant_cpu) begin
                  cpu_state <= cpu_we ? CPU_WACK : CPU_RWAIT;
                  cpu_ack   <= cpu_we;
               end
            end
            CPU_WACK: begin
               cpu_state <= CPU_IDLE;
            end
            CPU_RWAIT: begin
               cpu_rdata <= ram_rdata;
               cpu_ack   <= 1'b1;
               cpu_state <= CPU_RACK;
            end
            CPU_RACK: begin
               cpu_state <= CPU_IDLE;
            end
            default: begin
               cpu_state <= CPU_IDLE;
            end
         endcase
      end
   end

   // Count consecutive denied CPU cycles; saturate at the override threshold.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!cpu_req || grant_cpu) begin
         starve_cnt <= '0;
      end else if (cpu_pending && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end

   // Display read pipeline and drop reporting, independent of the CPU sequencer.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         disp_rd_pend <= 1'b0;
         disp_valid   <= 1'b0;
         disp_data    <= '0;
         disp_miss    <= 1'b0;
         miss_count   <= '0;
      end else begin
         disp_rd_pend <= grant_disp;
         disp_valid   <= disp_rd_pend;
         if (disp_rd_pend) begin
            disp_data <= ram_rdata;
         end
         disp_miss <= disp_dropped;
         if (disp_dropped && (miss_count != '1)) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_orao_vram_arbiter.sv
// Testbench for orao_vram_arbiter: bench-side RAM, a cycle-scheduled
// reference model checked every cycle, and directed scenarios with
// hand-computed expectations. A second instance with STARVE_LIMIT=1
// drives the miss counter into saturation.
module tb_orao_vram_arbiter;

   localparam int unsigned AW    = 13;
   localparam int unsigned LIMIT = 8;

   logic clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   int cyc = 0;
   always @(posedge clk_pixel) cyc <= cyc + 1;

   // main instance signals
   logic          reset = 1'b1;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic [7:0]    disp_data;
   logic          disp_valid;
   logic          disp_miss;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_wdata = '0;
   logic          cpu_ack;
   logic [7:0]    cpu_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;
   logic [15:0]   miss_count;

   // saturation instance signals
   logic          s_reset = 1'b1;
   logic          s_disp_req = 1'b1;
   logic [AW-1:0] s_disp_addr = '0;
   logic [7:0]    s_disp_data;
   logic          s_disp_valid;
   logic          s_disp_miss;
   logic          s_cpu_req = 1'b1;
   logic          s_cpu_we = 1'b1;
   logic [AW-1:0] s_cpu_addr = '0;
   logic [7:0]    s_cpu_wdata = 8'h11;
   logic          s_cpu_ack;
   logic [7:0]    s_cpu_rdata;
   logic [AW-1:0] s_ram_addr;
   logic          s_ram_we;
   logic [7:0]    s_ram_wdata;
   logic [7:0]    s_ram_rdata = '0;
   logic [15:0]   s_miss_count;

   orao_vram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .disp_req  (disp_req),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .disp_valid(disp_valid),
      .disp_miss (disp_miss),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .miss_count(miss_count)
   );

   orao_vram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(1)) sat_dut (
      .clk_pixel (clk_pixel),
      .reset     (s_reset),
      .disp_req  (s_disp_req),
      .disp_addr (s_disp_addr),
      .disp_data (s_disp_data),
      .disp_valid(s_disp_valid),
      .disp_miss (s_disp_miss),
      .cpu_req   (s_cpu_req),
      .cpu_we    (s_cpu_we),
      .cpu_addr  (s_cpu_addr),
      .cpu_wdata (s_cpu_wdata),
      .cpu_ack   (s_cpu_ack),
      .cpu_rdata (s_cpu_rdata),
      .ram_addr  (s_ram_addr),
      .ram_we    (s_ram_we),
      .ram_wdata (s_ram_wdata),
      .ram_rdata (s_ram_rdata),
      .miss_count(s_miss_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] init_byte(input int a);
      return 8'(a + 'h40);
   endfunction

   // Bench RAM: one-cycle read latency; unwritten locations hold a+0x40.
   logic [7:0] ram_mem [8192];
   bit         ram_wr  [8192];
   always @(posedge clk_pixel) begin
      ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_byte(int'(ram_addr));
      if (ram_we) begin
         ram_mem[ram_addr] <= ram_wdata;
         ram_wr[ram_addr]  <= 1'b1;
      end
   end

   // Event log used by the directed scenarios.
   int          ack_cnt = 0;
   int          last_ack_cyc = 0;
   int          miss_seen = 0;
   logic [7:0]  vq [$];
   int          vc [$];

   // Reference model: expected outputs are scheduled into future cycle
   // slots when a grant is decided; every cycle the DUT is checked.
   initial begin : monitor
      bit          sv_valid [8];
      logic [7:0]  sv_ddata [8];
      bit          sv_ack   [8];
      bit          sv_rd    [8];
      logic [7:0]  sv_rdata [8];
      bit          sv_miss  [8];
      logic [7:0]  m_mem    [8192];
      bit          m_wr     [8192];
      logic [7:0]  m_disp_data;
      logic [7:0]  m_cpu_rdata;
      logic [15:0] m_miss;
      logic [AW-1:0] m_last_addr;
      logic [AW-1:0] exp_addr;
      int          m_busy_until;
      int          m_wait;
      int          s;
      bit          cpu_free, g_cpu, g_disp;
      m_disp_data  = '0;
      m_cpu_rdata  = '0;
      m_miss       = '0;
      m_last_addr  = '0;
      m_busy_until = -1;
      m_wait       = 0;
      for (int i = 0; i < 8; i++) begin
         sv_valid[i] = 0; sv_ack[i] = 0; sv_rd[i] = 0; sv_miss[i] = 0;
         sv_ddata[i] = '0; sv_rdata[i] = '0;
      end
      forever begin
         @(negedge clk_pixel);
         s = cyc % 8;
         if (sv_valid[s]) m_disp_data = sv_ddata[s];
         if (sv_rd[s]) m_cpu_rdata = sv_rdata[s];
         chk("disp_valid", disp_valid, sv_valid[s]);
         chk("disp_data", disp_data, m_disp_data);
         chk("disp_miss", disp_miss, sv_miss[s]);
         chk("cpu_ack", cpu_ack, sv_ack[s]);
         chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
         chk("miss_count", miss_count, m_miss);
         if (disp_valid) begin vq.push_back(disp_data); vc.push_back(cyc); end
         if (cpu_ack) begin ack_cnt++; last_ack_cyc = cyc; end
         if (disp_miss) miss_seen++;
         sv_valid[s] = 0; sv_ack[s] = 0; sv_rd[s] = 0; sv_miss[s] = 0;

         if (reset) begin
            chk("ram_we_rst", ram_we, 0);
            chk("ram_addr_rst", ram_addr, 0);
            chk("ram_wdata_rst", ram_wdata, 0);
            for (int i = 0; i < 8; i++) begin
               sv_valid[i] = 0; sv_ack[i] = 0; sv_rd[i] = 0; sv_miss[i] = 0;
            end
            m_busy_until = -1;
            m_wait       = 0;
            m_last_addr  = '0;
            m_disp_data  = '0;
            m_cpu_rdata  = '0;
            m_miss       = '0;
         end else begin
            cpu_free = cpu_req && (cyc > m_busy_until);
            g_cpu    = cpu_free && ((m_wait == int'(LIMIT)) || !disp_req);
            g_disp   = disp_req && !g_cpu;
            exp_addr = m_last_addr;
            if (g_cpu) begin
               exp_addr = cpu_addr;
               if (cpu_we) begin
                  chk("ram_wdata", ram_wdata, cpu_wdata);
                  m_mem[cpu_addr] = cpu_wdata;
                  m_wr[cpu_addr]  = 1;
                  sv_ack[(cyc + 1) % 8] = 1;
                  m_busy_until = cyc + 1;
               end else begin
                  sv_ack[(cyc + 2) % 8]   = 1;
                  sv_rd[(cyc + 2) % 8]    = 1;
                  sv_rdata[(cyc + 2) % 8] = m_wr[cpu_addr] ? m_mem[cpu_addr] : init_byte(int'(cpu_addr));
                  m_busy_until = cyc + 2;
               end
            end else if (g_disp) begin
               exp_addr = disp_addr;
               sv_valid[(cyc + 2) % 8] = 1;
               sv_ddata[(cyc + 2) % 8] = m_wr[disp_addr] ? m_mem[disp_addr] : init_byte(int'(disp_addr));
            end
            chk("ram_addr", ram_addr, exp_addr);
            chk("ram_we", ram_we, g_cpu && cpu_we);
            if (g_cpu || g_disp) m_last_addr = exp_addr;
            if (disp_req && !g_disp) begin
               sv_miss[(cyc + 1) % 8] = 1;
               if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
            end
            if (!cpu_req || g_cpu) m_wait = 0;
            else if (cpu_free && (m_wait < int'(LIMIT))) m_wait++;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic await_ack(input int n0, input int bound, output bit got);
      got = 0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk_pixel);
         #1;
         if (ack_cnt != n0) got = 1;
      end
   endtask

   // Issue one CPU access from the current cycle and hold it until acked.
   task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                             input string nm, output int lat);
      int n0, t0;
      bit got;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      n0 = ack_cnt; t0 = cyc;
      await_ack(n0, 40, got);
      chk({nm, "_ack_seen"}, got, 1);
      next_cycle();
      cpu_req = 1'b0;
      lat = last_ack_cyc - t0;
   endtask

   initial begin : stim
      int  t0, n0, m0, lat, seen;
      bit  got;

      repeat (3) next_cycle();
      reset = 1'b0;
      @(negedge clk_pixel);
      #1;
      chk("rst_disp_data", disp_data, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_miss_count", miss_count, 0);
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);

      // display-only burst, addresses 0..7
      next_cycle();
      vq.delete(); vc.delete();
      t0 = cyc;
      for (int a = 0; a < 8; a++) begin
         disp_req = 1'b1; disp_addr = AW'(a);
         next_cycle();
      end
      disp_req = 1'b0;
      repeat (4) next_cycle();
      chk("burst_count", vq.size(), 8);
      for (int i = 0; i < 8 && i < vq.size(); i++) begin
         chk("burst_data", vq[i], 'h40 + i);
         chk("burst_cycle", vc[i] - t0, i + 2);
      end

      // CPU write then read-back at the top address
      cpu_access(1'b1, 13'h1FFF, 8'hA5, "wr1fff", lat);
      chk("wr1fff_latency", lat, 1);
      cpu_access(1'b0, 13'h1FFF, 8'h00, "rd1fff", lat);
      chk("rd1fff_latency", lat, 2);
      chk("rd1fff_data", cpu_rdata, 'hA5);

      // CPU read starved by continuous display traffic
      repeat (4) next_cycle();
      disp_req = 1'b1; disp_addr = 13'h0100;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
      t0 = cyc; n0 = ack_cnt; m0 = miss_seen; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk_pixel);
         #1;
         if (ack_cnt != n0) got = 1;
         next_cycle();
         disp_addr = disp_addr + 1'b1;
      end
      cpu_req = 1'b0; disp_req = 1'b0;
      chk("starve_ack_seen", got, 1);
      chk("starve_ack_latency", last_ack_cyc - t0, 10);
      chk("starve_miss_pulses", miss_seen - m0, 1);
      chk("starve_miss_count", miss_count, 1);
      chk("starve_rdata", cpu_rdata, 'h50);

      // simultaneous display and new CPU write: display first
      repeat (4) next_cycle();
      vq.delete(); vc.delete();
      disp_req = 1'b1; disp_addr = 13'h0003;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'h3C;
      t0 = cyc; n0 = ack_cnt; m0 = miss_seen;
      next_cycle();
      disp_req = 1'b0;
      await_ack(n0, 20, got);
      next_cycle();
      cpu_req = 1'b0;
      chk("tie_ack_seen", got, 1);
      chk("tie_ack_latency", last_ack_cyc - t0, 2);
      chk("tie_miss_pulses", miss_seen - m0, 0);
      chk("tie_valid_count", vq.size(), 1);
      if (vq.size() > 0) begin
         chk("tie_disp_data", vq[0], 'h43);
         chk("tie_valid_cycle", vc[0] - t0, 2);
      end

      // reset while a CPU read is waiting for RAM data
      repeat (4) next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
      n0 = ack_cnt;
      next_cycle();
      reset = 1'b1; cpu_req = 1'b0;
      next_cycle();
      reset = 1'b0;
      repeat (5) next_cycle();
      chk("rwait_rst_no_ack", ack_cnt - n0, 0);
      chk("rwait_rst_miss_count", miss_count, 0);
      chk("rwait_rst_cpu_rdata", cpu_rdata, 0);
      chk("rwait_rst_disp_data", disp_data, 0);
      chk("rwait_rst_ram_addr", ram_addr, 0);
      cpu_access(1'b1, 13'h0200, 8'h77, "post_rst_wr", lat);
      chk("post_rst_wr_latency", lat, 1);
      cpu_access(1'b0, 13'h0200, 8'h00, "post_rst_rd", lat);
      chk("post_rst_rd_latency", lat, 2);
      chk("post_rst_rd_data", cpu_rdata, 'h77);

      // miss counter saturation on the STARVE_LIMIT=1 instance
      next_cycle();
      s_reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 210000 && seen < 65537; i++) begin
         @(negedge clk_pixel);
         if (s_disp_miss) begin
            seen++;
            if (seen == 1 || seen == 1000 || seen == 65534)
               chk("sat_miss_count", s_miss_count, seen);
            else if (seen >= 65535)
               chk("sat_miss_count_held", s_miss_count, 'hFFFF);
         end
      end
      chk("sat_drops_reached", seen, 65537);
      chk("sat_final", s_miss_count, 'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/orao_vram_arbiter.md
ORAO_VRAM_ARBITER -- requirements
Module: orao_vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, video RAM address width (8 KB Orao frame buffer).
REQ-002 Parameter STARVE_LIMIT, default 8, number of consecutive denied CPU cycles after which the CPU overrides display priority; legal range 1..255.
REQ-003 clk_pixel  in  1  single clock for all logic; the RAM also runs on this clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 disp_req  in  1  display fetch strobe; one request per asserted cycle; no hold required.
REQ-006 disp_addr  in  ADDR_W  display fetch address, sampled when disp_req=1.
REQ-007 disp_data  out  8  registered display read data.
REQ-008 disp_valid  out  1  one-cycle pulse; disp_data updated this cycle.
REQ-009 disp_miss  out  1  one-cycle pulse; a display request was dropped.
REQ-010 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-011 cpu_we  in  1  1=write, 0=read; stable while cpu_req=1.
REQ-012 cpu_addr  in  ADDR_W  CPU address; stable while cpu_req=1.
REQ-013 cpu_wdata  in  8  CPU write data; stable while cpu_req=1.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 cpu_rdata  out  8  registered CPU read data; valid in the cpu_ack cycle of a read, held until the next read completes.
REQ-016 ram_addr  out  ADDR_W  single-port RAM address (combinational from the grant).
REQ-017 ram_we  out  1  RAM write enable (combinational).
REQ-018 ram_wdata  out  8  RAM write data (combinational).
REQ-019 ram_rdata  in  8  RAM read data, valid one cycle after the address is presented.
REQ-020 miss_count  out  16  saturating count of dropped display requests.

Function
REQ-021 At most one access is issued to the RAM per cycle; grant is decided in the request cycle (cycle N).
REQ-022 Priority in cycle N: if cpu pending, not in flight, and starve_cnt = STARVE_LIMIT -> grant CPU; else if disp_req -> grant display; else if cpu pending and not in flight -> grant CPU; else idle.
REQ-023 Idle cycle: ram_we=0; ram_addr holds the last granted address.
REQ-024 Display grant in N: ram_addr=disp_addr, ram_we=0; at N+2 disp_data=ram_rdata captured at end of N+1, with disp_valid=1 for that single cycle.
REQ-025 disp_req in N not granted (CPU override): disp_miss=1 in N+1; miss_count increments at end of N, saturating at 16'hFFFF; disp_data unchanged.
REQ-026 CPU write granted in N: ram_we=1, ram_addr=cpu_addr, ram_wdata=cpu_wdata in N; cpu_ack=1 in N+1.
REQ-027 CPU read granted in N: ram_we=0 in N; cpu_rdata=ram_rdata and cpu_ack=1 in N+2.
REQ-028 FSM CPU_IDLE -> (grant write) CPU_WACK -> CPU_IDLE; CPU_IDLE -> (grant read) CPU_RWAIT -> CPU_RACK -> CPU_IDLE; a CPU is "in flight" in every state other than CPU_IDLE; no new CPU grant while in flight.
REQ-029 In the cpu_ack cycle cpu_req is still high; no re-grant occurs in that cycle; the next CPU access is granted no earlier than the cycle after cpu_ack.
REQ-030 Display pipeline is independent of the CPU FSM: back-to-back display grants yield back-to-back disp_valid pulses; display and CPU read data paths never corrupt each other.
REQ-031 starve_cnt (8-bit): +1 at end of each cycle with cpu pending, not in flight, and not granted, saturating at STARVE_LIMIT; cleared on CPU grant or when cpu_req=0.
REQ-032 Simultaneous disp_req and new cpu_req with starve_cnt < STARVE_LIMIT: display wins; the CPU waits.

Reset
REQ-033 While reset=1 at a clock edge: FSM=CPU_IDLE, starve_cnt=0, miss_count=0, disp_data=0, cpu_rdata=0, disp_valid=0, disp_miss=0, cpu_ack=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-034 Reset during an in-flight access cancels it: no cpu_ack, disp_valid or disp_miss is produced after reset deasserts for a pre-reset grant.

Verification
REQ-035 Display only: disp_req on each cycle, addr 0..7, RAM[a]=a+0x40 -> disp_valid in 8 consecutive cycles starting at N+2, data 0x40..0x47, in order.
REQ-036 CPU write 0x1FFF<-0xA5 then read 0x1FFF, no display -> write ack at N+1; read ack at M+2 with cpu_rdata=0xA5.
REQ-037 Continuous disp_req with cpu read pending, STARVE_LIMIT=8 -> CPU granted on the 9th pending cycle; exactly one disp_miss; miss_count=1; cpu_ack 2 cycles after grant.
REQ-038 Same cycle disp_req and cpu_req (write), starve_cnt=0 -> display granted first; CPU granted in the next free cycle; no disp_miss.
REQ-039 Assert reset in the CPU_RWAIT cycle -> no cpu_ack; all outputs at reset values; next cpu_req after reset completes normally.
REQ-040 Force 65536 dropped display requests -> miss_count saturates at 0xFFFF and does not wrap.
